instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
- Sequential instruction encoder and loader. It is the write-side counterpart of the instruction decoder: it accepts instruction fields over a valid/ready handshake and packs them into INST_W-bit instruction words.
- It writes the words sequentially into instruction memory from a host-supplied base address.
- It sits between the test/boot host and instruction memory, and is used for program loading and self-test.
- Packing uses the decoder_pkg field-position constants, so every written word decodes back to the supplied fields.

Parameters:
- INST_W, 16, instruction word width
- DATA_W, 8, data immediate width
- I_ADDR_W, 12, instruction address width; also the width of the address immediate and of the count
- REG_ADDR_WIDTH, 4, register address width

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a load session
- base_address  input  I_ADDR_W  first imem address; sampled on start
- count  input  I_ADDR_W  number of instructions in the session; sampled on start
- in_valid  input  1  field set valid
- in_ready  output  1  encoder can accept a field set
- in_branch  input  1  1 = branch instruction
- in_branch_condition  input  branch_condition_e  branch condition
- in_op  input  opcode_e  opcode (ignored when in_branch=1)
- in_function  input  4  ALU or reg/mem function
- in_reg_addr  input  REG_ADDR_WIDTH  register address
- in_data_immediate  input  DATA_W  data immediate
- in_address_immediate  input  I_ADDR_W  address immediate
- imem_write_enable  output  1  instruction memory write strobe
- imem_address  output  I_ADDR_W  write address
- imem_write_data  output  INST_W  encoded word
- busy  output  1  session active
- done  output  1  one-cycle pulse at session end
- error  output  1  sticky illegal-field flag (feature-dependent)
- loaded_count  output  I_ADDR_W  words written in the current or last session

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE.
  - All outputs 0 at reset: in_ready, imem_write_enable, imem_address, imem_write_data, busy, done, error, loaded_count.
- States:
  - IDLE: on start, capture base_address into the address pointer, count into remaining, clear loaded_count and error. Go to RUN, or to DONE if count==0.
  - RUN: busy=1; in_ready=1.
    - Handshake in_valid&&in_ready accepts one field set and decrements remaining.
    - The accept that takes remaining to 0 moves the state to DONE.
  - DONE: one cycle; done=1, busy=0, in_ready=0; then IDLE.
- Encoding is registered, with one cycle of latency.
  - A field set accepted at edge N appears at edge N+1 as imem_write_enable=1, imem_address=pointer, imem_write_data=word.
  - After that write, pointer and loaded_count increment.
  - Full throughput: one word per cycle under back-to-back valid.
- Packing:
  - in_branch=1: BRANCH_INSTRUCTION_OFFSET bit=1, branch condition field, address immediate field.
  - Otherwise, branch bit=0 and op field=in_op, plus:
    - OPCODE_ARITH_LOGIC: function and reg_addr fields.
    - OPCODE_ARITH_LOGIC_IMM: function and data immediate fields.
    - OPCODE_REG_MEMORY with SET: function and data immediate fields.
    - OPCODE_REG_MEMORY, other functions: function and reg_addr fields.
    - OPCODE_JUMP_IMM: address immediate field.
    - OPCODE_JUMP_REG: function field (bit0: 0=JMPR, 1=JMP).
  - Bits not belonging to the selected fields are 0.
- Boundary conditions:
  - The address pointer wraps modulo 2^I_ADDR_W; the wrap is not an error.
  - start while busy is ignored.
  - in_valid outside RUN is ignored (in_ready=0).
  - The last write of a session occurs in the DONE cycle.
  - Reset mid-session aborts with no further writes; a partial program remains in memory.

Optional Feature:
- Macro: INSTRUCTION_ENCODER_CHECK_EN.
- Defined:
  - An accepted field set is illegal if in_op is not a valid opcode_e member, or if in_reg_addr/in_data_immediate are nonzero where the packing drops them.
  - An illegal set consumes its slot: remaining decrements and the pointer increments, so the address stays in lock-step with the host.
  - No write is issued for an illegal set; error is set and stays set until the next start.
- Undefined: no checking; error is tied to 0 and every accepted set is written.

Decomposition:
- decoder_pkg (existing) supplies field MSB/LSB constants, opcode_e, reg_mem_func_e and branch_condition_e; this block adds no new constants to it.
- New encoder_pkg holds encoder_state_e (IDLE, RUN, DONE).
- Sub-module instruction_packer: a purely combinational field-to-word function, reused by the bench's reference model.
- The FSM, counters and output register live in the top module.

Test Plan:
- start, base=0x010, count=3; ARITH_LOGIC reg 5, ARITH_LOGIC_IMM imm 0x7F, JUMP_IMM addr 0x123, back-to-back -> writes at 0x010/0x011/0x012 on consecutive cycles; done 1 cycle after the last accept; loaded_count=3; every word, fed to the decoder, reproduces its fields.
- REG_MEMORY SET imm 0xA5 then GET reg 3 -> SET word decodes acc_immediate=0xA5; GET word decodes read_get_acc=1 and reg_addr=3.
- Branch cond X, addr 0xFFF at base 0xFFF, count 2 -> writes at 0xFFF then 0x000; branch bit set in both words.
- count=0 -> done pulse one cycle after start; no imem writes; start pulsed during busy -> ignored.
- in_valid toggled 1,0,1 mid-session; rst_n low after the 2nd of 4 accepts -> all outputs 0 immediately; no further writes.
- With CHECK_EN, an illegal opcode as the 2nd of 3 entries -> writes at base and base+2 only; error=1 until the next start. Without CHECK_EN -> 3 writes; error=0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Instruction field layout shared by the decoder and the encoder/loader.
package decoder_pkg;

  localparam int BRANCH_INSTRUCTION_OFFSET = 15;
  localparam int BRANCH_CONDITION_MSB      = 14;
  localparam int BRANCH_CONDITION_LSB      = 12;
  localparam int OPCODE_MSB                = 14;
  localparam int OPCODE_LSB                = 12;
  localparam int FUNCTION_MSB              = 11;
  localparam int FUNCTION_LSB              = 8;
  localparam int REG_ADDR_MSB              = 3;
  localparam int REG_ADDR_LSB              = 0;
  localparam int DATA_IMMEDIATE_MSB        = 7;
  localparam int DATA_IMMEDIATE_LSB        = 0;
  localparam int ADDRESS_IMMEDIATE_MSB     = 11;
  localparam int ADDRESS_IMMEDIATE_LSB     = 0;

  typedef enum logic [2:0] {
    OPCODE_ARITH_LOGIC     = 3'd0,
    OPCODE_ARITH_LOGIC_IMM = 3'd1,
    OPCODE_REG_MEMORY      = 3'd2,
    OPCODE_JUMP_IMM        = 3'd3,
    OPCODE_JUMP_REG        = 3'd4
  } opcode_e;

  typedef enum logic [3:0] {
    REG_MEM_SET   = 4'd0,
    REG_MEM_GET   = 4'd1,
    REG_MEM_LOAD  = 4'd2,
    REG_MEM_STORE = 4'd3
  } reg_mem_func_e;

  typedef enum logic [2:0] {
    BRANCH_ZERO      = 3'd0,
    BRANCH_NOT_ZERO  = 3'd1,
    BRANCH_CARRY     = 3'd2,
    BRANCH_NOT_CARRY = 3'd3,
    BRANCH_NEGATIVE  = 3'd4,
    BRANCH_POSITIVE  = 3'd5,
    BRANCH_OVERFLOW  = 3'd6,
    BRANCH_ALWAYS    = 3'd7
  } branch_condition_e;

endpackage

// File: rtl/encoder_pkg.sv
// Types private to the instruction encoder/loader.
package encoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } encoder_state_e;

endpackage

// File: rtl/instruction_packer.sv
// Combinational field-set to instruction-word packer; unused fields are zero.
module instruction_packer
  import decoder_pkg::*;
#(
  parameter int INST_W         = 16,
  parameter int DATA_W         = 8,
  parameter int I_ADDR_W       = 12,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      branch,
  input  branch_condition_e         branch_condition,
  input  opcode_e                   op,
  input  logic [3:0]                func,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic [DATA_W-1:0]         data_immediate,
  input  logic [I_ADDR_W-1:0]       address_immediate,
  output logic [INST_W-1:0]         word
);

  always_comb begin
    word = '0;
    if (branch) begin
      word[BRANCH_INSTRUCTION_OFFSET]                          = 1'b1;
      word[BRANCH_CONDITION_MSB:BRANCH_CONDITION_LSB]          = branch_condition;
      word[ADDRESS_IMMEDIATE_MSB:ADDRESS_IMMEDIATE_LSB]        = address_immediate;
    end else begin
      word[OPCODE_MSB:OPCODE_LSB] = op;
      case (op)
        OPCODE_ARITH_LOGIC: begin
          word[FUNCTION_MSB:FUNCTION_LSB] = func;
          word[REG_ADDR_MSB:REG_ADDR_LSB] = reg_addr;
        end
        OPCODE_ARITH_LOGIC_IMM: begin
          word[FUNCTION_MSB:FUNCTION_LSB]             = func;
          word[DATA_IMMEDIATE_MSB:DATA_IMMEDIATE_LSB] = data_immediate;
        end
        OPCODE_REG_MEMORY: begin
          word[FUNCTION_MSB:FUNCTION_LSB] = func;
          // SET carries an immediate; the other reg/mem functions name a register
          if (func == REG_MEM_SET)
            word[DATA_IMMEDIATE_MSB:DATA_IMMEDIATE_LSB] = data_immediate;
          else
            word[REG_ADDR_MSB:REG_ADDR_LSB] = reg_addr;
        end
        OPCODE_JUMP_IMM:
          word[ADDRESS_IMMEDIATE_MSB:ADDRESS_IMMEDIATE_LSB] = address_immediate;
        OPCODE_JUMP_REG:
          word[FUNCTION_MSB:FUNCTION_LSB] = func;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Sequential instruction encoder/loader: packs accepted field sets and writes them to imem.
// Define INSTRUCTION_ENCODER_CHECK_EN to drop illegal field sets and raise the sticky error flag.
module instruction_encoder
  import decoder_pkg::*;
  import encoder_pkg::*;
#(
  parameter int INST_W         = 16,
  parameter int DATA_W         = 8,
  parameter int I_ADDR_W       = 12,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [I_ADDR_W-1:0]       base_address,
  input  logic [I_ADDR_W-1:0]       count,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_branch,
  input  branch_condition_e         in_branch_condition,
  input  opcode_e                   in_op,
  input  logic [3:0]                in_function,
  input  logic [REG_ADDR_WIDTH-1:0] in_reg_addr,
  input  logic [DATA_W-1:0]         in_data_immediate,
  input  logic [I_ADDR_W-1:0]       in_address_immediate,
  output logic                      imem_write_enable,
  output logic [I_ADDR_W-1:0]       imem_address,
  output logic [INST_W-1:0]         imem_write_data,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [I_ADDR_W-1:0]       loaded_count
);

  encoder_state_e      state;
  logic [I_ADDR_W-1:0] pointer;
  logic [I_ADDR_W-1:0] remaining;
  logic [INST_W-1:0]   word;
  logic                illegal;
  logic                accept;

  assign accept = (state == RUN) && in_ready && in_valid;

  instruction_packer #(
    .INST_W         (INST_W),
    .DATA_W         (DATA_W),
    .I_ADDR_W       (I_ADDR_W),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_packer (
    .branch            (in_branch),
    .branch_condition  (in_branch_condition),
    .op                (in_op),
    .func              (in_function),
    .reg_addr          (in_reg_addr),
    .data_immediate    (in_data_immediate),
    .address_immediate (in_address_immediate),
    .word              (word)
  );

`ifdef INSTRUCTION_ENCODER_CHECK_EN
  logic reg_used;
  logic data_used;
  logic op_valid;

  always_comb begin
    reg_used  = 1'b0;
    data_used = 1'b0;
    op_valid  = 1'b1;
    if (!in_branch) begin
      case (in_op)
        OPCODE_ARITH_LOGIC:     reg_used  = 1'b1;
        OPCODE_ARITH_LOGIC_IMM: data_used = 1'b1;
        OPCODE_REG_MEMORY:
          if (in_function == REG_MEM_SET) data_used = 1'b1;
          else                             reg_used  = 1'b1;
        OPCODE_JUMP_IMM, OPCODE_JUMP_REG: ;
        default:                op_valid  = 1'b0;
      endcase
    end
  end

  assign illegal = !op_valid
                || (!reg_used  && (in_reg_addr != '0))
                || (!data_used && (in_data_immediate != '0));
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      pointer           <= '0;
      remaining         <= '0;
      in_ready          <= 1'b0;
      imem_write_enable <= 1'b0;
      imem_address      <= '0;
      imem_write_data   <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      loaded_count      <= '0;
    end else begin
      imem_write_enable <= 1'b0;
      done              <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pointer      <= base_address;
            remaining    <= count;
            loaded_count <= '0;
            error        <= 1'b0;
            if (count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= RUN;
              busy     <= 1'b1;
              in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            // an illegal set still consumes its address slot
            remaining         <= remaining - 1'b1;
            pointer           <= pointer + 1'b1;
            imem_write_enable <= !illegal;
            imem_address      <= pointer;
            imem_write_data   <= word;
            if (illegal) error <= 1'b1;
            else         loaded_count <= loaded_count + 1'b1;
            if (remaining == I_ADDR_W'(1)) begin
              state    <= DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b0;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder against a field-level reference model.
module tb_instruction_encoder;
  import decoder_pkg::*;

  typedef struct packed {
    logic       br;
    logic [2:0] cond;
    logic [2:0] op;
    logic [3:0] fn;
    logic [3:0] ra;
    logic [7:0] di;
    logic [11:0] ai;
  } fs_t;

  typedef struct packed {
    logic [11:0] a;
    logic [15:0] d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [11:0]       base_address;
  logic [11:0]       count;
  logic              in_valid;
  logic              in_ready;
  logic              in_branch;
  branch_condition_e in_branch_condition;
  opcode_e           in_op;
  logic [3:0]        in_function;
  logic [3:0]        in_reg_addr;
  logic [7:0]        in_data_immediate;
  logic [11:0]       in_address_immediate;
  logic              imem_write_enable;
  logic [11:0]       imem_address;
  logic [15:0]       imem_write_data;
  logic              busy;
  logic              done;
  logic              error;
  logic [11:0]       loaded_count;

  int  n_cmp = 0;
  int  n_err = 0;
  fs_t items[$];
  wr_t log_q[$];

  always #5 clk = ~clk;

  instruction_encoder dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .base_address         (base_address),
    .count                (count),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_branch            (in_branch),
    .in_branch_condition  (in_branch_condition),
    .in_op                (in_op),
    .in_function          (in_function),
    .in_reg_addr          (in_reg_addr),
    .in_data_immediate    (in_data_immediate),
    .in_address_immediate (in_address_immediate),
    .imem_write_enable    (imem_write_enable),
    .imem_address         (imem_address),
    .imem_write_data      (imem_write_data),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .loaded_count         (loaded_count)
  );

  // instruction memory as seen by the host: every strobed write, in order
  always @(posedge clk)
    if (rst_n && imem_write_enable) log_q.push_back('{a: imem_address, d: imem_write_data});

  function automatic logic [15:0] model_word(input fs_t f);
    logic [15:0] w;
    if (f.br)
      return (16'd1 << BRANCH_INSTRUCTION_OFFSET) | (16'(f.cond) << BRANCH_CONDITION_LSB)
           | (16'(f.ai) << ADDRESS_IMMEDIATE_LSB);
    w = 16'(f.op) << OPCODE_LSB;
    case (f.op)
      3'd0: w = w | (16'(f.fn) << FUNCTION_LSB) | (16'(f.ra) << REG_ADDR_LSB);
      3'd1: w = w | (16'(f.fn) << FUNCTION_LSB) | (16'(f.di) << DATA_IMMEDIATE_LSB);
      3'd2: w = w | (16'(f.fn) << FUNCTION_LSB)
              | ((f.fn == 4'd0) ? (16'(f.di) << DATA_IMMEDIATE_LSB) : (16'(f.ra) << REG_ADDR_LSB));
      3'd3: w = w | (16'(f.ai) << ADDRESS_IMMEDIATE_LSB);
      3'd4: w = w | (16'(f.fn) << FUNCTION_LSB);
      default: ;
    endcase
    return w;
  endfunction

  function automatic fs_t rand_fs();
    fs_t f;
    f.br   = ($urandom_range(0, 3) == 0);
    f.cond = 3'($urandom_range(0, 7));
    f.op   = 3'($urandom_range(0, 4));
    f.fn   = 4'($urandom_range(0, 15));
    f.ra   = 4'($urandom_range(0, 15));
    f.di   = 8'($urandom_range(0, 255));
    f.ai   = 12'($urandom_range(0, 4095));
    if (f.op == 3'd2 && $urandom_range(0, 1) == 1) f.fn = 4'd0;
`ifdef INSTRUCTION_ENCODER_CHECK_EN
    // keep the checked build legal: zero whatever the packing drops
    if (f.br || f.op == 3'd3 || f.op == 3'd4) begin f.ra = 4'd0; f.di = 8'd0; end
    else if (f.op == 3'd0 || (f.op == 3'd2 && f.fn != 4'd0)) f.di = 8'd0;
    else f.ra = 4'd0;
`endif
    return f;
  endfunction

  task automatic set_fields(input fs_t f);
    in_branch            = f.br;
    in_branch_condition  = branch_condition_e'(f.cond);
    in_op                = opcode_e'(f.op);
    in_function          = f.fn;
    in_reg_addr          = f.ra;
    in_data_immediate    = f.di;
    in_address_immediate = f.ai;
  endtask

  task automatic start_session(input logic [11:0] b, input logic [11:0] c);
    @(negedge clk);
    base_address = b;
    count        = c;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_items(input bit gaps);
    foreach (items[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      set_fields(items[i]);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, imem_write_enable, busy, done, error} !== 5'b0 || imem_address !== 12'h0
        || imem_write_data !== 16'h0 || loaded_count !== 12'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b cnt=%h, expected all 0",
               in_ready, imem_write_enable, imem_address, imem_write_data, busy, done, error, loaded_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b in_ready=%b, expected 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    int  b;
    fs_t f;
    b = log_q.size();
    items.delete();
    f = '0; f.op = OPCODE_ARITH_LOGIC;     f.fn = 4'h3; f.ra = 4'd5;    items.push_back(f);
    f = '0; f.op = OPCODE_ARITH_LOGIC_IMM; f.fn = 4'h2; f.di = 8'h7F;   items.push_back(f);
    f = '0; f.op = OPCODE_JUMP_IMM;        f.ai = 12'h123;              items.push_back(f);
    start_session(12'h010, 12'd3);
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_run: got busy=%b in_ready=%b, expected 1 1", busy, in_ready);
    end
    drive_items(1'b0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || loaded_count !== 12'd3) begin
      n_err++;
      $display("FAIL basic_done: got done=%b busy=%b loaded=%0d, expected 1 0 3", done, busy, loaded_count);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_pulse: got done=%b, expected 0", done);
    end
    n_cmp++;
    if (log_q.size() !== b + 3) begin
      n_err++;
      $display("FAIL basic_write_count: got %0d, expected 3", log_q.size() - b);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (log_q.size() <= b + i) begin
        n_err++;
        $display("FAIL basic_write%0d: no write, expected addr %h", i, 12'h010 + 12'(i));
      end else if (log_q[b+i].a !== 12'h010 + 12'(i) || log_q[b+i].d !== model_word(items[i])) begin
        n_err++;
        $display("FAIL basic_write%0d: got %h@%h, expected %h@%h", i, log_q[b+i].d, log_q[b+i].a,
                 model_word(items[i]), 12'h010 + 12'(i));
      end
    end
    if (log_q.size() >= b + 3) begin
      logic [15:0] w0, w1, w2;
      w0 = log_q[b].d; w1 = log_q[b+1].d; w2 = log_q[b+2].d;
      n_cmp++;
      if (w0[15] !== 1'b0 || w0[14:12] !== 3'd0 || w0[11:8] !== 4'h3 || w0[3:0] !== 4'd5
          || w1[14:12] !== 3'd1 || w1[7:0] !== 8'h7F || w2[14:12] !== 3'd3 || w2[11:0] !== 12'h123) begin
        n_err++;
        $display("FAIL basic_decode: got %h %h %h, expected fields op0/f3/r5, op1/7F, op3/123", w0, w1, w2);
      end
    end
  endtask

  task automatic test_reg_memory();
    int  b;
    fs_t f;
    b = log_q.size();
    items.delete();
    f = '0; f.op = OPCODE_REG_MEMORY; f.fn = REG_MEM_SET; f.di = 8'hA5; items.push_back(f);
    f = '0; f.op = OPCODE_REG_MEMORY; f.fn = REG_MEM_GET; f.ra = 4'd3;  items.push_back(f);
    start_session(12'h100, 12'd2);
    drive_items(1'b0);
    @(negedge clk);
    n_cmp++;
    if (log_q.size() !== b + 2) begin
      n_err++;
      $display("FAIL regmem_count: got %0d writes, expected 2", log_q.size() - b);
    end else begin
      logic [15:0] ws, wg;
      ws = log_q[b].d; wg = log_q[b+1].d;
      n_cmp++;
      if (ws[14:12] !== 3'd2 || ws[11:8] !== 4'd0 || ws[7:0] !== 8'hA5 || ws !== model_word(items[0])) begin
        n_err++;
        $display("FAIL regmem_set: got %h, expected %h (acc_immediate A5)", ws, model_word(items[0]));
      end
      n_cmp++;
      if (wg[11:8] !== 4'd1 || wg[3:0] !== 4'd3 || wg !== model_word(items[1])) begin
        n_err++;
        $display("FAIL regmem_get: got %h, expected %h (get, reg 3)", wg, model_word(items[1]));
      end
    end
  endtask

  task automatic test_wrap();
    int  b;
    fs_t f;
    b = log_q.size();
    items.delete();
    f = '0; f.br = 1'b1; f.cond = BRANCH_ALWAYS; f.ai = 12'hFFF;
    items.push_back(f);
    items.push_back(f);
    start_session(12'hFFF, 12'd2);
    drive_items(1'b0);
    @(negedge clk);
    n_cmp++;
    if (log_q.size() !== b + 2) begin
      n_err++;
      $display("FAIL wrap_count: got %0d writes, expected 2", log_q.size() - b);
    end else begin
      n_cmp++;
      if (log_q[b].a !== 12'hFFF || log_q[b+1].a !== 12'h000) begin
        n_err++;
        $display("FAIL wrap_addr: got %h,%h, expected fff,000", log_q[b].a, log_q[b+1].a);
      end
      n_cmp++;
      if (log_q[b].d !== model_word(f) || log_q[b+1].d !== model_word(f) || log_q[b].d[15] !== 1'b1) begin
        n_err++;
        $display("FAIL wrap_word: got %h,%h, expected %h", log_q[b].d, log_q[b+1].d, model_word(f));
      end
    end
    n_cmp++;
    if (error !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_error: got %b, expected 0", error);
    end
  endtask

  task automatic test_zero_and_busy_start();
    int b;
    b = log_q.size();
    start_session(12'h3A0, 12'd0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done: got done=%b busy=%b rdy=%b, expected 1 0 0", done, busy, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL zero_pulse: got done=%b, expected 0", done);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (log_q.size() !== b) begin
      n_err++;
      $display("FAIL zero_writes: got %0d writes, expected 0", log_q.size() - b);
    end
    items.delete();
    items.push_back(rand_fs());
    items.push_back(rand_fs());
    start_session(12'h200, 12'd2);
    @(negedge clk);
    base_address = 12'h300;
    count        = 12'd5;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_items(1'b0);
    n_cmp++;
    if (done !== 1'b1 || loaded_count !== 12'd2) begin
      n_err++;
      $display("FAIL busy_start_done: got done=%b loaded=%0d, expected 1 2", done, loaded_count);
    end
    @(negedge clk);
    n_cmp++;
    if (log_q.size() !== b + 2) begin
      n_err++;
      $display("FAIL busy_start_count: got %0d writes, expected 2", log_q.size() - b);
    end else if (log_q[b].a !== 12'h200 || log_q[b+1].a !== 12'h201
                 || log_q[b].d !== model_word(items[0]) || log_q[b+1].d !== model_word(items[1])) begin
      n_err++;
      $display("FAIL busy_start_writes: got %h@%h %h@%h, expected %h@200 %h@201", log_q[b].d, log_q[b].a,
               log_q[b+1].d, log_q[b+1].a, model_word(items[0]), model_word(items[1]));
    end
  endtask

  task automatic test_gaps_and_reset();
    int b;
    b = log_q.size();
    items.delete();
    for (int i = 0; i < 4; i++) items.push_back(rand_fs());
    start_session(12'h040, 12'd4);
    @(negedge clk); set_fields(items[0]); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); set_fields(items[1]); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || loaded_count !== 12'd2) begin
      n_err++;
      $display("FAIL gaps_progress: got busy=%b loaded=%0d, expected 1 2", busy, loaded_count);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, imem_write_enable, busy, done, error} !== 5'b0 || imem_address !== 12'h0
        || imem_write_data !== 16'h0 || loaded_count !== 12'h0) begin
      n_err++;
      $display("FAIL abort_outputs: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b cnt=%h, expected all 0",
               in_ready, imem_write_enable, imem_address, imem_write_data, busy, done, loaded_count);
    end
    set_fields(items[2]);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (log_q.size() !== b + 2 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_writes: got %0d writes busy=%b, expected 2 0", log_q.size() - b, busy);
    end else if (log_q[b].a !== 12'h040 || log_q[b+1].a !== 12'h041
                 || log_q[b].d !== model_word(items[0]) || log_q[b+1].d !== model_word(items[1])) begin
      n_err++;
      $display("FAIL abort_partial: got %h@%h %h@%h, expected %h@040 %h@041", log_q[b].d, log_q[b].a,
               log_q[b+1].d, log_q[b+1].a, model_word(items[0]), model_word(items[1]));
    end
  endtask

  task automatic test_check();
    int  b;
    fs_t f;
    b = log_q.size();
    items.delete();
    f = '0; f.op = OPCODE_ARITH_LOGIC; f.fn = 4'd1; f.ra = 4'd2; items.push_back(f);
    f = '0; f.op = 3'd7;                                       items.push_back(f);
    f = '0; f.op = OPCODE_JUMP_IMM;    f.ai = 12'h055;          items.push_back(f);
    start_session(12'h080, 12'd3);
    drive_items(1'b0);
    @(negedge clk);
`ifdef INSTRUCTION_ENCODER_CHECK_EN
    n_cmp++;
    if (log_q.size() !== b + 2) begin
      n_err++;
      $display("FAIL check_count: got %0d writes, expected 2", log_q.size() - b);
    end else if (log_q[b].a !== 12'h080 || log_q[b+1].a !== 12'h082
                 || log_q[b].d !== model_word(items[0]) || log_q[b+1].d !== model_word(items[2])) begin
      n_err++;
      $display("FAIL check_writes: got %h@%h %h@%h, expected %h@080 %h@082", log_q[b].d, log_q[b].a,
               log_q[b+1].d, log_q[b+1].a, model_word(items[0]), model_word(items[2]));
    end
    n_cmp++;
    if (error !== 1'b1 || loaded_count !== 12'd2) begin
      n_err++;
      $display("FAIL check_error: got error=%b loaded=%0d, expected 1 2", error, loaded_count);
    end
`else
    n_cmp++;
    if (log_q.size() !== b + 3) begin
      n_err++;
      $display("FAIL check_count: got %0d writes, expected 3", log_q.size() - b);
    end else if (log_q[b].a !== 12'h080 || log_q[b+1].a !== 12'h081 || log_q[b+2].a !== 12'h082
                 || log_q[b+1].d !== model_word(items[1]) || log_q[b+2].d !== model_word(items[2])) begin
      n_err++;
      $display("FAIL check_writes: got %h@%h %h@%h, expected %h@081 %h@082", log_q[b+1].d, log_q[b+1].a,
               log_q[b+2].d, log_q[b+2].a, model_word(items[1]), model_word(items[2]));
    end
    n_cmp++;
    if (error !== 1'b0 || loaded_count !== 12'd3) begin
      n_err++;
      $display("FAIL check_error: got error=%b loaded=%0d, expected 0 3", error, loaded_count);
    end
`endif
    repeat (2) @(negedge clk);
    start_session(12'h000, 12'd0);
    n_cmp++;
    if (error !== 1'b0 || loaded_count !== 12'd0) begin
      n_err++;
      $display("FAIL check_clear: got error=%b loaded=%0d after start, expected 0 0", error, loaded_count);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int          b;
    int          cnt;
    logic [11:0] base_r;
    for (int s = 0; s < 8; s++) begin
      b      = log_q.size();
      cnt    = $urandom_range(1, 8);
      base_r = 12'($urandom_range(4088, 4095));
      if (s % 2 == 0) base_r = 12'($urandom_range(0, 4095));
      items.delete();
      for (int i = 0; i < cnt; i++) items.push_back(rand_fs());
      start_session(base_r, 12'(cnt));
      drive_items(1'b1);
      n_cmp++;
      if (done !== 1'b1 || loaded_count !== 12'(cnt)) begin
        n_err++;
        $display("FAIL rand%0d_done: got done=%b loaded=%0d, expected 1 %0d", s, done, loaded_count, cnt);
      end
      @(negedge clk);
      n_cmp++;
      if (log_q.size() !== b + cnt) begin
        n_err++;
        $display("FAIL rand%0d_count: got %0d writes, expected %0d", s, log_q.size() - b, cnt);
      end
      for (int i = 0; i < cnt; i++) begin
        if (log_q.size() > b + i) begin
          n_cmp++;
          if (log_q[b+i].a !== base_r + 12'(i) || log_q[b+i].d !== model_word(items[i])) begin
            n_err++;
            $display("FAIL rand%0d_write%0d: got %h@%h, expected %h@%h", s, i, log_q[b+i].d,
                     log_q[b+i].a, model_word(items[i]), base_r + 12'(i));
          end
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before summary, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b1;
    start        = 1'b0;
    base_address = '0;
    count        = '0;
    in_valid     = 1'b0;
    set_fields('0);
    #2;
    test_reset();
    test_basic();
    test_reg_memory();
    test_wrap();
    test_zero_and_busy_start();
    test_gaps_and_reset();
    test_check();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
